ctrl_pipe: RTL
==============

Name: ctrl_pipe

Overview:
- Consumer side of the instruction control decoder. Takes the WB_ctrl/M_ctrl/EX_ctrl bundles produced in ID and carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and inserts bubbles. Resolves branch/jump redirects in MEM and flushes the younger instructions.
- Generates forwarding selects and saturating stall/flush counters.
- Sits between the ID-stage decoder and the EX/MEM/WB datapath.

Parameters:
CNT_W, 32, width of stall_cnt and flush_cnt

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
id_opcode  in  7  opcode of instruction in ID
id_wb  in  WB_ctrl  WB bundle from decoder
id_m  in  M_ctrl  M bundle from decoder
id_ex  in  EX_ctrl  EX bundle from decoder
id_rs1  in  5  rs1 field in ID
id_rs2  in  5  rs2 field in ID
id_rd  in  5  rd field in ID
br_cond  in  1  branch-compare result for the instruction in MEM
ex_wb, ex_m, ex_ex  out  bundles  ID/EX register contents
mem_wb, mem_m  out  bundles  EX/MEM register contents
wb_wb  out  WB_ctrl  MEM/WB register contents
ex_rd, mem_rd, wb_rd  out  5  destination register per stage
fwd_a, fwd_b  out  2  ALU operand forwarding select
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID update enable
if_id_flush  out  1  IF/ID clear
pc_src  out  1  redirect PC to branch/jump target
stall_cnt, flush_cnt  out  CNT_W  event counters

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous and active-low. Reset dominates stall and flush, including mid-operation.
- BUBBLE constant: all bundle fields 0, except M.CS=1 (memory deselected) and EX.ALUsrc=2'b00, EX.ALUop=DOADD.
- Reset values:
  - All stage bundles = BUBBLE.
  - All *_rd, ex_rs1, ex_rs2 = 0.
  - Counters = 0.
  - Combinational outputs follow from the registered state.
- rs use decode (combinational on id_opcode):
  - uses_rs1 for 0110011, 0010011, 0000011, 0100011, 1100111, 1100011.
  - uses_rs2 for 0110011, 0100011, 1100011.
  - All other opcodes, including unknown ones: neither.
- Load-use hazard (combinational): hz = ex_m.MemRead & ex_rd!=0 & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)).
- Redirect (combinational): pc_src = mem_m.jump | (mem_m.branch & br_cond).
- Control outputs:
  - pc_write = if_id_write = ~hz | pc_src.
  - if_id_flush = pc_src.
- Per-edge update, priority reset > redirect > hazard > normal:
  - Redirect: ID/EX <- BUBBLE, EX/MEM <- BUBBLE (the two younger instructions are killed). MEM/WB <- mem bundles (the jump still writes PC+4). flush_cnt++.
  - Hazard (no redirect): ID/EX <- BUBBLE. EX/MEM and MEM/WB advance normally. IF/ID and PC hold via outputs. stall_cnt++.
  - Normal: ID/EX <- id bundles plus id_rd/id_rs1/id_rs2. EX/MEM <- ex. MEM/WB <- mem.
- Bubble register fields: a bubble sets rd=0 and rs1=rs2=0.
- Latency: one cycle per stage.
- Counter width: counters saturate at 2^CNT_W-1; they do not wrap.
- Forwarding (combinational on registered state; fwd_b uses ex_rs2 in the same way as fwd_a):
  - fwd_a = 2'b10 if mem_wb.RegWrite & mem_rd!=0 & mem_rd==ex_rs1.
  - Else 2'b01 if wb_wb.RegWrite & wb_rd!=0 & wb_rd==ex_rs1.
  - Else 2'b00.
  - EX/MEM has priority over MEM/WB when both match.
- x0 never triggers a hazard or forwarding.

Decomposition:
- my_pkg: WB_ctrl, M_ctrl, EX_ctrl, the ALUop enum, the BUBBLE_WB/BUBBLE_M/BUBBLE_EX constants, and the FWD_RF/FWD_MEM/FWD_WB localparams.
- One sub-module, rs_use_decode: id_opcode -> uses_rs1, uses_rs2.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with non-bubble inputs -> all stages BUBBLE (M.CS=1), counters 0, fwd_a=fwd_b=00, pc_write=1.
- Load-use: lw x5 (opcode 0000011, rd=5), then add using rs1=5 -> for one cycle pc_write=0, if_id_write=0, ex bundle BUBBLE next edge, stall_cnt=1. Then add proceeds with fwd_a=01 in its EX cycle.
- No false stall: lw x5, then lui x6 (id_rs1 field=5) -> no stall, since lui does not use rs1; likewise lw x0 then add rs1=0 -> no stall.
- Forward priority: add x7 followed by sub x7 followed by and using rs1=7 -> fwd_a=10 (EX/MEM wins); rd=0 with RegWrite=1 -> fwd_a=00.
- Taken branch: beq reaches MEM with br_cond=1 -> pc_src=1, if_id_flush=1, ID/EX and EX/MEM BUBBLE next edge, flush_cnt=1. With br_cond=0 -> no flush. Redirect concurrent with hazard -> flush wins, stall_cnt unchanged.
- Saturation and reset mid-run: CNT_W=2 with 5 stalls -> stall_cnt=3. Assert rst_n=0 during a stall -> next edge everything reset.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared control-bundle types, bubble constants, opcode and forwarding
// encodings for the ID -> EX -> MEM -> WB control pipeline.
package ctrl_pipe_pkg;

    typedef enum logic [3:0] {
        DOADD = 4'd0,
        DOSUB = 4'd1,
        DOAND = 4'd2,
        DOOR  = 4'd3,
        DOXOR = 4'd4,
        DOSLT = 4'd5,
        DOSLL = 4'd6,
        DOSRL = 4'd7
    } alu_op_e;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] MemtoReg;
    } WB_ctrl;

    typedef struct packed {
        logic MemRead;
        logic MemWrite;
        logic CS;       // chip select, 1 = memory deselected
        logic branch;
        logic jump;
    } M_ctrl;

    typedef struct packed {
        logic [1:0] ALUsrc;
        alu_op_e    ALUop;
    } EX_ctrl;

    // A bubble is a no-op that never writes a register and keeps memory deselected.
    localparam WB_ctrl BUBBLE_WB = '{RegWrite: 1'b0, MemtoReg: 2'b00};
    localparam M_ctrl  BUBBLE_M  = '{MemRead: 1'b0, MemWrite: 1'b0, CS: 1'b1,
                                     branch: 1'b0, jump: 1'b0};
    localparam EX_ctrl BUBBLE_EX = '{ALUsrc: 2'b00, ALUop: DOADD};

    // Forwarding select encodings for the ALU operand muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Opcodes whose register source fields are meaningful.
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Forwarding select for one operand; the younger EX/MEM producer wins,
    // and x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic       mem_regwrite,
        input logic [4:0] mem_rd,
        input logic       wb_regwrite,
        input logic [4:0] wb_rd,
        input logic [4:0] rs
    );
        logic [1:0] sel;
        if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_pipe_rs_use_decode.sv
// Tells which register source fields the instruction in ID actually reads,
// so that hazard detection ignores garbage rs fields (e.g. lui, jal).
module rs_use_decode
    import ctrl_pipe_pkg::*;
(
    input  logic [6:0] id_opcode,
    output logic       uses_rs1,
    output logic       uses_rs2
);

    // Opcode lookup; unknown opcodes read no registers.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode)
            OP_R: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_IMM:  uses_rs1 = 1'b1;
            OP_LOAD: uses_rs1 = 1'b1;
            OP_JALR: uses_rs1 = 1'b1;
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-side pipeline: carries decoder bundles through ID/EX, EX/MEM and
// MEM/WB, inserts load-use bubbles, kills younger work on a MEM redirect,
// produces ALU forwarding selects and saturating stall/flush counters.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       id_opcode,
    input  WB_ctrl           id_wb,
    input  M_ctrl            id_m,
    input  EX_ctrl           id_ex,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             br_cond,
    output WB_ctrl           ex_wb,
    output M_ctrl            ex_m,
    output EX_ctrl           ex_ex,
    output WB_ctrl           mem_wb,
    output M_ctrl            mem_m,
    output WB_ctrl           wb_wb,
    output logic [4:0]       ex_rd,
    output logic [4:0]       mem_rd,
    output logic [4:0]       wb_rd,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             pc_src,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    WB_ctrl           ex_wb_r, mem_wb_r, wb_wb_r;
    M_ctrl            ex_m_r, mem_m_r;
    EX_ctrl           ex_ex_r;
    logic [4:0]       ex_rd_r, ex_rs1_r, ex_rs2_r, mem_rd_r, wb_rd_r;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

    logic uses_rs1_s, uses_rs2_s;
    logic hz_s, pc_src_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    rs_use_decode u_rs_use_decode (
        .id_opcode (id_opcode),
        .uses_rs1  (uses_rs1_s),
        .uses_rs2  (uses_rs2_s)
    );

    // Load-use hazard, MEM-stage redirect and forwarding selects.
    always_comb begin
        hz_s = ex_m_r.MemRead && (ex_rd_r != 5'd0) &&
               ((uses_rs1_s && (id_rs1 == ex_rd_r)) ||
                (uses_rs2_s && (id_rs2 == ex_rd_r)));
        pc_src_s = mem_m_r.jump || (mem_m_r.branch && br_cond);
        fwd_a_s  = fwd_sel(mem_wb_r.RegWrite, mem_rd_r, wb_wb_r.RegWrite, wb_rd_r, ex_rs1_r);
        fwd_b_s  = fwd_sel(mem_wb_r.RegWrite, mem_rd_r, wb_wb_r.RegWrite, wb_rd_r, ex_rs2_r);
    end

    // ID/EX register: a bubble replaces the ID instruction on redirect or stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_wb_r  <= BUBBLE_WB;
            ex_m_r   <= BUBBLE_M;
            ex_ex_r  <= BUBBLE_EX;
            ex_rd_r  <= 5'd0;
            ex_rs1_r <= 5'd0;
            ex_rs2_r <= 5'd0;
        end else if (pc_src_s || hz_s) begin
            ex_wb_r  <= BUBBLE_WB;
            ex_m_r   <= BUBBLE_M;
            ex_ex_r  <= BUBBLE_EX;
            ex_rd_r  <= 5'd0;
            ex_rs1_r <= 5'd0;
            ex_rs2_r <= 5'd0;
        end else begin
            ex_wb_r  <= id_wb;
            ex_m_r   <= id_m;
            ex_ex_r  <= id_ex;
            ex_rd_r  <= id_rd;
            ex_rs1_r <= id_rs1;
            ex_rs2_r <= id_rs2;
        end
    end

    // EX/MEM register: the instruction in EX is killed when MEM redirects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_wb_r <= BUBBLE_WB;
            mem_m_r  <= BUBBLE_M;
            mem_rd_r <= 5'd0;
        end else if (pc_src_s) begin
            mem_wb_r <= BUBBLE_WB;
            mem_m_r  <= BUBBLE_M;
            mem_rd_r <= 5'd0;
        end else begin
            mem_wb_r <= ex_wb_r;
            mem_m_r  <= ex_m_r;
            mem_rd_r <= ex_rd_r;
        end
    end

    // MEM/WB register: always advances, so a jump still retires its link write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_wb_r <= BUBBLE_WB;
            wb_rd_r <= 5'd0;
        end else begin
            wb_wb_r <= mem_wb_r;
            wb_rd_r <= mem_rd_r;
        end
    end

    // Stall counter: counts load-use bubbles not overridden by a redirect, saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (hz_s && !pc_src_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Flush counter: counts MEM redirects, saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (pc_src_s && (flush_cnt_r != CNT_MAX)) begin
            flush_cnt_r <= flush_cnt_r + CNT_ONE;
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign ex_wb       = ex_wb_r;
    assign ex_m        = ex_m_r;
    assign ex_ex       = ex_ex_r;
    assign mem_wb      = mem_wb_r;
    assign mem_m       = mem_m_r;
    assign wb_wb       = wb_wb_r;
    assign ex_rd       = ex_rd_r;
    assign mem_rd      = mem_rd_r;
    assign wb_rd       = wb_rd_r;
    assign fwd_a       = fwd_a_s;
    assign fwd_b       = fwd_b_s;
    assign pc_write    = !hz_s || pc_src_s;
    assign if_id_write = !hz_s || pc_src_s;
    assign if_id_flush = pc_src_s;
    assign pc_src      = pc_src_s;
    assign stall_cnt   = stall_cnt_r;
    assign flush_cnt   = flush_cnt_r;

endmodule
